// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with IF/ID register; define IF_PERF_CNT_EN to enable the fetch_cnt counter
module inst_fetch #(
  parameter logic [9:0]  RESET_PC  = 10'd0,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [9:0]  br_target,
  input  logic [31:0] imReDat,
  output logic [9:0]  imReDat_addr,
  output logic [31:0] ifid_inst,
  output logic [9:0]  ifid_pc,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [9:0]  ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        halted_q;
  logic        fetch_go;
  logic        is_halt_inst;

  // Memory is addressed straight from the PC so the word is available in the fetching cycle
  assign imReDat_addr = pc_q;
  assign is_halt_inst = (imReDat == HALT_INST);

  // A real fetch happens only when nothing of higher priority claims the cycle and we are not halted
  assign fetch_go = !br_taken && !flush && !stall && fetch_en && (state_q != HALT);

  // Next-state, next-PC and next IF/ID contents, resolved in priority order
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (br_taken) begin
      // Redirect wins over everything, including a halt
      pc_d         = br_target;
      ifid_inst_d  = 32'd0;
      ifid_pc_d    = 10'd0;
      ifid_valid_d = 1'b0;
      state_d      = RUN;
    end else if (flush) begin
      ifid_inst_d  = 32'd0;
      ifid_pc_d    = 10'd0;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      // Everything holds its value
      state_d = state_q;
    end else if (fetch_go) begin
      ifid_inst_d  = imReDat;
      ifid_pc_d    = pc_q;
      ifid_valid_d = 1'b1;
      if (is_halt_inst) begin
        // The halt word is passed down as valid but the PC stays on it
        state_d = HALT;
      end else begin
        pc_d    = pc_q + 10'd1;
        state_d = RUN;
      end
    end else begin
      // IDLE without enable, RUN with enable low, or HALT: insert a bubble
      ifid_inst_d  = 32'd0;
      ifid_pc_d    = 10'd0;
      ifid_valid_d = 1'b0;
    end
  end

  // State, PC and IF/ID register; halted is registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      ifid_inst_q  <= 32'd0;
      ifid_pc_q    <= 10'd0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= (state_d == HALT);
    end
  end

  assign ifid_inst  = ifid_inst_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = halted_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // Count edges that load a real instruction, sticking at all-ones
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (fetch_go && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // Fetch counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`else
  assign fetch_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with a behavioural fetch model
module tb_inst_fetch;

  localparam logic [9:0]  RESET_PC  = 10'd0;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [9:0]  br_target;
  logic [31:0] imReDat;
  logic [9:0]  imReDat_addr;
  logic [31:0] ifid_inst;
  logic [9:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_cnt;

  logic [31:0] mem [0:1023];

  int checks;
  int errors;

  // model of architectural state
  int          m_state;
  int          m_pc;
  logic [31:0] m_inst;
  int          m_ifpc;
  logic        m_valid;
  longint      m_cnt;

  inst_fetch #(
    .RESET_PC (RESET_PC),
    .HALT_INST(HALT_WORD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .flush       (flush),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imReDat     (imReDat),
    .imReDat_addr(imReDat_addr),
    .ifid_inst   (ifid_inst),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid),
    .halted      (halted),
    .fetch_cnt   (fetch_cnt)
  );

  assign imReDat = mem[imReDat_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt();
`ifdef IF_PERF_CNT_EN
    return m_cnt[31:0];
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    m_pc    = int'(RESET_PC);
    m_inst  = 32'd0;
    m_ifpc  = 0;
    m_valid = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_bubble();
    m_inst  = 32'd0;
    m_ifpc  = 0;
    m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, clock the DUT, land 1ns after the edge
  task automatic step(input logic fe, input logic st, input logic fl, input logic bt,
                      input logic [9:0] tgt);
    logic [31:0] w;
    fetch_en  = fe;
    stall     = st;
    flush     = fl;
    br_taken  = bt;
    br_target = tgt;
    w = mem[m_pc];
    if (bt) begin
      m_pc    = int'(tgt);
      m_state = S_RUN;
      model_bubble();
    end else if (fl) begin
      model_bubble();
    end else if (st) begin
      m_pc = m_pc;
    end else if (m_state == S_HALT || !fe) begin
      model_bubble();
    end else begin
      m_inst  = w;
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (w == HALT_WORD) begin
        m_state = S_HALT;
      end else begin
        m_pc    = (m_pc + 1) % 1024;
        m_state = S_RUN;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fetch_en = 0; stall = 0; flush = 0; br_taken = 0; br_target = 10'd0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (ifid_valid !== 1'b0 || ifid_inst !== 32'd0 || ifid_pc !== 10'd0) begin
      errors++;
      $display("FAIL reset_ifid: valid=%b inst=%h pc=%0d, required 0/0/0", ifid_valid, ifid_inst, ifid_pc);
    end
    checks++;
    if (halted !== 1'b0 || fetch_cnt !== 32'd0 || imReDat_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_misc: halted=%b cnt=%0d addr=%0d, required 0/0/%0d", halted, fetch_cnt, imReDat_addr, RESET_PC);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    checks++;
    if (ifid_valid !== 1'b0 || imReDat_addr !== RESET_PC) begin
      errors++;
      $display("FAIL idle_hold: valid=%b addr=%0d, required 0/%0d", ifid_valid, imReDat_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] words [4];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
      checks++;
      if (ifid_inst !== words[i] || ifid_pc !== 10'(i) || ifid_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_fetch%0d: inst=%h pc=%0d valid=%b, required %h/%0d/1", i, ifid_inst, ifid_pc, ifid_valid, words[i], i);
      end
    end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
      checks++;
      if (imReDat_addr !== 10'd5 || ifid_pc !== 10'd4 || ifid_inst !== mem[4] || ifid_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: addr=%0d ifid_pc=%0d inst=%h, required 5/4/%h", i, imReDat_addr, ifid_pc, ifid_inst, mem[4]);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    checks++;
    if (ifid_pc !== 10'd5 || ifid_inst !== mem[5] || imReDat_addr !== 10'd6) begin
      errors++;
      $display("FAIL stall_resume: ifid_pc=%0d inst=%h addr=%0d, required 5/%h/6", ifid_pc, ifid_inst, imReDat_addr, mem[5]);
    end
  endtask

  task automatic test_branch_stall();
    step(1'b1, 1'b1, 1'b0, 1'b1, 10'd700);
    checks++;
    if (ifid_valid !== 1'b0 || imReDat_addr !== 10'd700) begin
      errors++;
      $display("FAIL br_stall: valid=%b addr=%0d, required 0/700", ifid_valid, imReDat_addr);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    checks++;
    if (ifid_pc !== 10'd700 || ifid_valid !== 1'b1 || ifid_inst !== mem[700]) begin
      errors++;
      $display("FAIL br_fetch: ifid_pc=%0d valid=%b inst=%h, required 700/1/%h", ifid_pc, ifid_valid, ifid_inst, mem[700]);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 1'b0, 1'b1, 10'd1023);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    checks++;
    if (ifid_pc !== 10'd1023 || imReDat_addr !== 10'd0) begin
      errors++;
      $display("FAIL wrap: ifid_pc=%0d addr=%0d, required 1023/0", ifid_pc, imReDat_addr);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    checks++;
    if (ifid_pc !== 10'd0 || ifid_inst !== mem[0]) begin
      errors++;
      $display("FAIL wrap_next: ifid_pc=%0d inst=%h, required 0/%h", ifid_pc, ifid_inst, mem[0]);
    end
  endtask

  task automatic test_halt();
    step(1'b1, 1'b0, 1'b0, 1'b1, 10'd8);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    checks++;
    if (ifid_valid !== 1'b1 || ifid_inst !== HALT_WORD || ifid_pc !== 10'd8 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_capture: valid=%b inst=%h pc=%0d halted=%b, required 1/ffffffff/8/1", ifid_valid, ifid_inst, ifid_pc, halted);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
      checks++;
      if (ifid_valid !== 1'b0 || halted !== 1'b1 || imReDat_addr !== 10'd8) begin
        errors++;
        $display("FAIL halt_hold%0d: valid=%b halted=%b addr=%0d, required 0/1/8", i, ifid_valid, halted, imReDat_addr);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 10'd20);
    checks++;
    if (halted !== 1'b0 || imReDat_addr !== 10'd20 || ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_exit: halted=%b addr=%0d valid=%b, required 0/20/0", halted, imReDat_addr, ifid_valid);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    checks++;
    if (ifid_pc !== 10'd20 || ifid_valid !== 1'b1) begin
      errors++;
      $display("FAIL halt_refetch: ifid_pc=%0d valid=%b, required 20/1", ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_perf_cnt();
    logic [31:0] want;
    test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 10'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
`ifdef IF_PERF_CNT_EN
    want = 32'd6;
`else
    want = 32'd0;
`endif
    checks++;
    if (fetch_cnt !== want) begin
      errors++;
      $display("FAIL perf_cnt: fetch_cnt=%0d, required %0d", fetch_cnt, want);
    end
    checks++;
    if (imReDat_addr !== 10'd6) begin
      errors++;
      $display("FAIL perf_pc: addr=%0d, required 6", imReDat_addr);
    end
  endtask

  task automatic test_random();
    logic fe, st, fl, bt;
    logic [9:0] tgt;
    for (int i = 0; i < 400; i++) begin
      fe  = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      bt  = ($urandom_range(0, 15) == 0);
      tgt = 10'($urandom_range(0, 1023));
      step(fe, st, fl, bt, tgt);
      checks++;
      if (ifid_inst !== m_inst || ifid_pc !== 10'(m_ifpc) || ifid_valid !== m_valid ||
          imReDat_addr !== 10'(m_pc) || halted !== (m_state == S_HALT) || fetch_cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL rand%0d: inst=%h pc=%0d v=%b addr=%0d h=%b cnt=%0d, required %h/%0d/%b/%0d/%b/%0d",
                 i, ifid_inst, ifid_pc, ifid_valid, imReDat_addr, halted, fetch_cnt,
                 m_inst, m_ifpc, m_valid, m_pc, (m_state == S_HALT), exp_cnt());
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 10'd100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifid_valid !== 1'b0 || ifid_inst !== 32'd0 || ifid_pc !== 10'd0 || halted !== 1'b0 ||
        fetch_cnt !== 32'd0 || imReDat_addr !== RESET_PC) begin
      errors++;
      $display("FAIL async_reset: v=%b inst=%h pc=%0d h=%b cnt=%0d addr=%0d, required all 0, addr %0d",
               ifid_valid, ifid_inst, ifid_pc, halted, fetch_cnt, imReDat_addr, RESET_PC);
    end
    model_reset();
    fetch_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    checks++;
    if (ifid_pc !== RESET_PC || ifid_inst !== mem[RESET_PC] || ifid_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_fetch: ifid_pc=%0d inst=%h valid=%b, required %0d/%h/1", ifid_pc, ifid_inst, ifid_valid, RESET_PC, mem[RESET_PC]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    fetch_en = 0; stall = 0; flush = 0; br_taken = 0; br_target = 10'd0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT_WORD) mem[i] = 32'h1;
    end
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h44;
    mem[8] = HALT_WORD;
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_wrap();
    test_halt();
    test_perf_cnt();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
